// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt/exception arbiter.
// Holds the FSM state encoding, the priority and cause field widths, the
// vector addresses the downstream sequencer selects with intEXC, and a helper
// that packs the cause field.
package int_ctrl_pkg;

  // Arbiter FSM states. The encodings are fixed so that they read the same in
  // waveforms and in the sequencer documentation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } ctrlStateT;

  // Width of a device priority and of the current PSR priority field.
  localparam int PRI_W = 3;

  // Cause field layout: {exc, idx[2:0]}.
  localparam int IDX_W         = 3;
  localparam int CAUSE_W       = 4;
  localparam int CAUSE_EXC_BIT = 3;

  // Vector addresses the sequencer uses for int_exc = 0 and int_exc = 1.
  localparam logic [15:0] VEC_INT = 16'h0040;
  localparam logic [15:0] VEC_EXC = 16'h0044;

  // Pack an exception flag and a device index into the cause field.
  function automatic logic [CAUSE_W-1:0] makeCause(input logic exc,
                                                   input logic [IDX_W-1:0] idx);
    logic [CAUSE_W-1:0] cause;
    cause                = '0;
    cause[CAUSE_EXC_BIT] = exc;
    cause[IDX_W-1:0]     = idx;
    return cause;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_sel.sv
// int_prio_sel: combinational priority picker for device interrupts.
// Ports:
//   pending - latched device request vector (NDEV bits)
//   psrPri  - current processor priority taken from psr[10:8]
//   valid   - at least one pending device outranks the current priority
//   idx     - index of the winning device (highest priority, lowest index on tie)
module int_prio_sel
  import int_ctrl_pkg::*;
#(
  parameter int                      NDEV    = 4,
  parameter logic [PRI_W*NDEV-1:0]   DEV_PRI = 12'o7421
) (
  input  logic [NDEV-1:0]  pending,
  input  logic [PRI_W-1:0] psrPri,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [PRI_W-1:0] bestPri;

  // Scan devices from index 0 upward. A device only replaces the current
  // winner when its priority is strictly higher, so on a tie the lowest
  // index keeps the grant. Devices at or below the PSR priority are masked.
  always_comb begin
    valid   = 1'b0;
    idx     = '0;
    bestPri = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (pending[i] && (DEV_PRI[PRI_W*i +: PRI_W] > psrPri) &&
          (!valid || (DEV_PRI[PRI_W*i +: PRI_W] > bestPri))) begin
        valid   = 1'b1;
        idx     = IDX_W'(i);
        bestPri = DEV_PRI[PRI_W*i +: PRI_W];
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt/exception arbiter feeding the interrupt sequencer.
// Latches device interrupt pulses and exception requests, picks a winner
// against the current PSR priority, holds int_req/int_exc/int_cause until the
// sequencer reports completion with a rising edge on int_done, then clears the
// serviced source. A request that sits unanswered for TIMEOUT cycles is
// abandoned and flagged on the sticky seq_err output.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-low reset
//   dev_irq   - device interrupt pulses/levels (NDEV)
//   dev_ie    - per-device interrupt enables (NDEV)
//   exc_req   - one-cycle exception pulse from decode
//   psr       - processor status register, psr[10:8] is the current priority
//   int_done  - sequencer int_r_out, rising edge means service complete
//   int_req   - request to the sequencer (int_r)
//   int_exc   - exception vector select to the sequencer (intEXC)
//   int_cause - {exc, idx[2:0]} of the source being serviced
//   dev_ack   - one-hot, one-cycle clear pulse to the serviced device
//   pending   - latched pending device vector
//   seq_err   - sticky sequencer timeout flag
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int                    NDEV    = 4,
  parameter logic [PRI_W*NDEV-1:0] DEV_PRI = 12'o7421,
  parameter int                    TIMEOUT = 64,
  parameter int                    CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NDEV-1:0]    dev_irq,
  input  logic [NDEV-1:0]    dev_ie,
  input  logic               exc_req,
  input  logic [15:0]        psr,
  input  logic               int_done,
  output logic               int_req,
  output logic               int_exc,
  output logic [CAUSE_W-1:0] int_cause,
  output logic [NDEV-1:0]    dev_ack,
  output logic [NDEV-1:0]    pending,
  output logic               seq_err
);

  ctrlStateT          state, stateNext;
  logic [CNT_W-1:0]   counter, counterNext;
  logic               doneD;
  logic               doneEdge;
  logic               excPend;
  logic               clrExc;
  logic               selValid;
  logic [IDX_W-1:0]   selIdx;
  logic               reqNext;
  logic               excNext;
  logic [CAUSE_W-1:0] causeNext;
  logic [NDEV-1:0]    devAckNext;
  logic               errNext;
  logic [12:0]        unusedPsr;

  // Only the priority field of the PSR matters to the arbiter.
  assign unusedPsr = {psr[15:11], psr[7:0]};

  // Device picker; its result is only acted on while the FSM is idle.
  int_prio_sel #(
    .NDEV    (NDEV),
    .DEV_PRI (DEV_PRI)
  ) prioSel (
    .pending (pending),
    .psrPri  (psr[10:8]),
    .valid   (selValid),
    .idx     (selIdx)
  );

  // A completion is a 0->1 transition of int_done. doneD powers up high so a
  // sequencer that is already holding int_done high is never taken as done.
  assign doneEdge = int_done & ~doneD;

  // The exception flag is released during the ACK cycle of an exception grant.
  assign clrExc = (state == ACK) & int_exc;

  // Next-state and next-output logic. Outputs are registered so the sequencer
  // sees clean, glitch-free request lines; this block decides what they
  // become on the next edge. A grant freezes cause/exc until the next grant,
  // and a completion in the same cycle as the timeout still counts as done.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    reqNext     = int_req;
    excNext     = int_exc;
    causeNext   = int_cause;
    devAckNext  = '0;
    errNext     = seq_err;
    case (state)
      IDLE: begin
        if (excPend) begin
          stateNext   = REQ;
          reqNext     = 1'b1;
          excNext     = 1'b1;
          causeNext   = makeCause(1'b1, IDX_W'(0));
          counterNext = '0;
        end else if (selValid) begin
          stateNext   = REQ;
          reqNext     = 1'b1;
          excNext     = 1'b0;
          causeNext   = makeCause(1'b0, selIdx);
          counterNext = '0;
        end
      end
      REQ: begin
        counterNext = counter + 1'b1;
        if (doneEdge) begin
          stateNext   = ACK;
          reqNext     = 1'b0;
          counterNext = '0;
          if (!int_exc) begin
            devAckNext = NDEV'(1) << int_cause[IDX_W-1:0];
          end
        end else if (counter == CNT_W'(TIMEOUT - 1)) begin
          stateNext   = IDLE;
          reqNext     = 1'b0;
          errNext     = 1'b1;
          counterNext = '0;
        end
      end
      ACK: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        reqNext   = 1'b0;
      end
    endcase
  end

  // FSM state, timeout counter and registered sequencer-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      int_req   <= 1'b0;
      int_exc   <= 1'b0;
      int_cause <= '0;
      dev_ack   <= '0;
      seq_err   <= 1'b0;
    end else begin
      state     <= stateNext;
      counter   <= counterNext;
      int_req   <= reqNext;
      int_exc   <= excNext;
      int_cause <= causeNext;
      dev_ack   <= devAckNext;
      seq_err   <= errNext;
    end
  end

  // Source latches. dev_ack doubles as the clear for the serviced device; a
  // fresh pulse landing on the same bit as its clear is kept so the device is
  // serviced again rather than silently lost. Disabling a device drops it.
  // Exception requests merge into a single flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      excPend <= 1'b0;
      doneD   <= 1'b1;
    end else begin
      pending <= ((pending & ~dev_ack) | dev_irq) & dev_ie;
      excPend <= exc_req | (excPend & ~clrExc);
      doneD   <= int_done;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl. Expected causes are pushed onto a
// scoreboard queue when stimulus is driven and popped when the arbiter raises
// int_req. Inputs are driven and outputs sampled on the falling clock edge.
module tb_int_ctrl;

  localparam int NDEV    = 4;
  localparam int TIMEOUT = 64;

  logic            clk;
  logic            reset;
  logic [NDEV-1:0] dev_irq;
  logic [NDEV-1:0] dev_ie;
  logic            exc_req;
  logic [15:0]     psr;
  logic            int_done;
  logic            int_req;
  logic            int_exc;
  logic [3:0]      int_cause;
  logic [NDEV-1:0] dev_ack;
  logic [NDEV-1:0] pending;
  logic            seq_err;

  int testsRun;
  int testsFailed;

  logic [3:0] expQ[$];

  int_ctrl #(
    .NDEV    (NDEV),
    .DEV_PRI (12'o7421),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_irq   (dev_irq),
    .dev_ie    (dev_ie),
    .exc_req   (exc_req),
    .psr       (psr),
    .int_done  (int_done),
    .int_req   (int_req),
    .int_exc   (int_exc),
    .int_cause (int_cause),
    .dev_ack   (dev_ack),
    .pending   (pending),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside a bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, testsFailed=%0d", testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive one cycle of device/exception pulses, then return them to idle.
  task automatic applyStimulus(input logic [NDEV-1:0] irq, input logic exc);
    dev_irq = irq;
    exc_req = exc;
    tick();
    dev_irq = '0;
    exc_req = 1'b0;
  endtask

  // Raise int_done for one cycle; returns on the falling edge of the ACK cycle.
  task automatic raiseDone();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  task automatic waitReq(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (int_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [3:0] popExp();
    if (expQ.size() == 0) return 4'hF;
    return expQ.pop_front();
  endfunction

  task automatic test_reset();
    logic [3:0] exp;
    reset    = 1'b0;
    dev_irq  = '0;
    dev_ie   = '1;
    exc_req  = 1'b0;
    psr      = 16'h0000;
    int_done = 1'b0;
    tick();
    tick();
    exp = 4'h0;
    testsRun++;
    if ({int_req, int_exc, dev_ack, pending, seq_err} !== 11'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got req=%b exc=%b ack=%b pend=%b err=%b, want all 0",
               int_req, int_exc, dev_ack, pending, seq_err);
    end
    testsRun++;
    if (int_cause !== exp) begin
      testsFailed++;
      $display("[TB] FAIL reset_cause: got %h want %h", int_cause, exp);
    end
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single();
    logic [3:0] exp;
    expQ.push_back(4'h1);
    applyStimulus(4'b0010, 1'b0);
    testsRun++;
    if (int_req !== 1'b0 || pending !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL single_latch: got req=%b pend=%b want req=0 pend=0010", int_req, pending);
    end
    tick();
    testsRun++;
    if (int_req !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_req_latency: got req=%b want 1", int_req);
    end
    exp = popExp();
    testsRun++;
    if ({int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL single_cause: got exc=%b cause=%h want exc=%b cause=%h",
               int_exc, int_cause, exp[3], exp);
    end
    tick();
    tick();
    raiseDone();
    testsRun++;
    if (int_req !== 1'b0 || dev_ack !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL single_ack: got req=%b ack=%b want req=0 ack=0010", int_req, dev_ack);
    end
    tick();
    testsRun++;
    if (dev_ack !== 4'b0000 || pending !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL single_clear: got ack=%b pend=%b want 0000/0000", dev_ack, pending);
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp;
    bit         seen;
    int         extraReqs;
    psr = 16'h0300;
    expQ.push_back(4'h3);
    applyStimulus(4'b1001, 1'b0);
    waitReq(5, seen);
    exp = popExp();
    testsRun++;
    if (!seen || {int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL prio_winner: seen=%b got exc=%b cause=%h want exc=%b cause=%h",
               seen, int_exc, int_cause, exp[3], exp);
    end
    raiseDone();
    testsRun++;
    if (dev_ack !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL prio_ack: got %b want 1000", dev_ack);
    end
    extraReqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int_req !== 1'b0) extraReqs++;
    end
    testsRun++;
    if (extraReqs != 0 || pending !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL prio_masked: got reqCycles=%0d pend=%b want 0 and 0001", extraReqs, pending);
    end
    dev_ie = 4'b1110;
    tick();
    dev_ie = 4'b1111;
    psr    = 16'h0000;
    tick();
  endtask

  task automatic test_exception();
    logic [3:0] exp;
    bit         seen;
    expQ.push_back(4'h8);
    expQ.push_back(4'h3);
    applyStimulus(4'b1000, 1'b1);
    waitReq(5, seen);
    exp = popExp();
    testsRun++;
    if (!seen || {int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL exc_first: seen=%b got exc=%b cause=%h want exc=%b cause=%h",
               seen, int_exc, int_cause, exp[3], exp);
    end
    raiseDone();
    testsRun++;
    if (int_req !== 1'b0 || dev_ack !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL exc_ack: got req=%b ack=%b want req=0 ack=0000", int_req, dev_ack);
    end
    tick();
    testsRun++;
    if (int_req !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL exc_gap: got req=%b want 0", int_req);
    end
    tick();
    exp = popExp();
    testsRun++;
    if (int_req !== 1'b1 || {int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL exc_then_dev: got req=%b exc=%b cause=%h want req=1 exc=%b cause=%h",
               int_req, int_exc, int_cause, exp[3], exp);
    end
    raiseDone();
    testsRun++;
    if (dev_ack !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL exc_dev_ack: got %b want 1000", dev_ack);
    end
    tick();
    testsRun++;
    if (pending !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL exc_dev_clear: got %b want 0000", pending);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp;
    bit         seen;
    int         reqCycles;
    int_done = 1'b1;
    reset    = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    testsRun++;
    if (seq_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL timeout_err_init: got %b want 0", seq_err);
    end
    expQ.push_back(4'h2);
    applyStimulus(4'b0100, 1'b0);
    waitReq(5, seen);
    exp = popExp();
    testsRun++;
    if (!seen || {int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL timeout_req: seen=%b got exc=%b cause=%h want exc=%b cause=%h",
               seen, int_exc, int_cause, exp[3], exp);
    end
    reqCycles = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (int_req !== 1'b1) break;
      reqCycles++;
    end
    testsRun++;
    if (reqCycles != TIMEOUT) begin
      testsFailed++;
      $display("[TB] FAIL timeout_len: got %0d cycles want %0d", reqCycles, TIMEOUT);
    end
    testsRun++;
    if (int_req !== 1'b0 || seq_err !== 1'b1 || pending !== 4'b0100 || dev_ack !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL timeout_abort: got req=%b err=%b pend=%b ack=%b want 0/1/0100/0000",
               int_req, seq_err, pending, dev_ack);
    end
    expQ.push_back(4'h2);
    waitReq(4, seen);
    exp = popExp();
    testsRun++;
    if (!seen || {int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL timeout_retry: seen=%b got exc=%b cause=%h want exc=%b cause=%h",
               seen, int_exc, int_cause, exp[3], exp);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    tick();
    testsRun++;
    if (int_req !== 1'b1 || seq_err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_pre: got req=%b err=%b want 1/1", int_req, seq_err);
    end
    #2;
    reset = 1'b0;
    #1;
    testsRun++;
    if ({int_req, pending, int_cause, seq_err} !== 10'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_async: got req=%b pend=%b cause=%h err=%b want all 0",
               int_req, pending, int_cause, seq_err);
    end
    tick();
    reset    = 1'b1;
    int_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    bit         seen;
    expQ.push_back(4'h2);
    applyStimulus(4'b0100, 1'b0);
    waitReq(5, seen);
    exp = popExp();
    testsRun++;
    if (!seen || {int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: seen=%b got exc=%b cause=%h want exc=%b cause=%h",
               seen, int_exc, int_cause, exp[3], exp);
    end
    psr = 16'h0700;
    tick();
    tick();
    tick();
    testsRun++;
    if (int_req !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_psr_hold: got req=%b want 1", int_req);
    end
    raiseDone();
    testsRun++;
    if (dev_ack !== 4'b0100) begin
      testsFailed++;
      $display("[TB] FAIL b2b_ack: got %b want 0100", dev_ack);
    end
    psr = 16'h0000;
    expQ.push_back(4'h2);
    applyStimulus(4'b0100, 1'b0);
    testsRun++;
    if (pending[2] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_set_wins: got pend=%b want bit2 set", pending);
    end
    waitReq(5, seen);
    exp = popExp();
    testsRun++;
    if (!seen || {int_exc, int_cause} !== {exp[3], exp}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: seen=%b got exc=%b cause=%h want exc=%b cause=%h",
               seen, int_exc, int_cause, exp[3], exp);
    end
    raiseDone();
    tick();
    testsRun++;
    if (pending !== 4'b0000 || int_req !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_final: got pend=%b req=%b want 0000/0", pending, int_req);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_single();
    test_priority();
    test_exception();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
